// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: mode encodings, the
// park/run state enum and a small mode-classification helper.
package clk_ctrl_pkg;

    localparam logic [1:0] MODE_FAST = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    // ST_PARK: clk held low. ST_RUN: clk toggling at the active divider.
    typedef enum logic {
        ST_PARK = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // FAST and SLOW toggle continuously; STEP and HALT do not.
    function automatic logic is_free_run(input logic [1:0] m);
        return (m == MODE_FAST) || (m == MODE_SLOW);
    endfunction

endpackage

// File: rtl/clk_ctrl_unit_switch_debouncer.sv
// Debouncer for the raw continue switch: 2-FF synchroniser followed by a
// stability counter. 'level' follows the switch once it has been stable for
// DEB_CYCLES samples; 'settled' goes high the first time any level has been
// confirmed, so the caller can tell a genuine 0 from the reset value.
module switch_debouncer #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic sw_raw,
    output logic level,
    output logic settled
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic          cand;
    logic [DW-1:0] cnt;

    // Synchronise the raw switch into the CLOCK_50 domain
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= sw_raw;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive equal samples; commit the level once the run is long enough
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cand    <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            settled <= 1'b0;
        end else if (sync_2 != cand) begin
            cand <= sync_2;
            cnt  <= DW'(1);
        end else if (cnt == DW'(DEB_CYCLES - 1)) begin
            level   <= cand;
            settled <= 1'b1;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/clk_ctrl_unit.sv
// CPU clock generator: FAST / SLOW / STEP-burst / HALT from CLOCK_50.
// Mode changes land only on a half-period boundary after which clk is low,
// so a high pulse is never shortened. Optional breakpoint logic is enabled
// with the BREAKPOINT_EN macro.
module clk_ctrl_unit
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_W      = 29,
    parameter int DIV_FAST   = 25,
    parameter int DIV_SLOW   = 50000000,
    parameter int DEB_CYCLES = 500000,
    parameter int STEP_W     = 4,
    parameter int CYC_W      = 32
`ifdef BREAKPOINT_EN
    ,
    parameter int PC_W       = 32
`endif
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [1:0]        sel_clock,
    input  logic              continue_switch,
    input  logic [STEP_W-1:0] step_count,
`ifdef BREAKPOINT_EN
    input  logic              bp_valid,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc_in,
    output logic              bp_hit,
`endif
    output logic              clk,
    output logic              clk_rise,
    output logic              running,
    output logic [CYC_W-1:0]  cycle_count
);

    logic [1:0]        sel_s1, sel_s2;
    logic [1:0]        mode, mode_n, new_mode;
    run_state_t        state, state_n;
    logic [CNT_W-1:0]  count, count_n, div_act;
    logic              clk_n, rise_n;
    logic [CYC_W-1:0]  cycle_n;
    logic [STEP_W-1:0] step_remain, step_n;
    logic              deb_level, deb_settled, deb_prev, armed;
    logic              at_bnd, mode_upd, step_pulse, bp_hit_n;

    switch_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .sw_raw   (continue_switch),
        .level    (deb_level),
        .settled  (deb_settled)
    );

    // One pulse per debounced press; disarmed until a settled low is seen
    assign step_pulse = armed && deb_level && !deb_prev;

    // The running flag is the park/run state itself
    assign running = (state == ST_RUN);

    // Divider limit for the current mode; STEP and HALT share the FAST rate
    always_comb begin
        div_act = CNT_W'(DIV_FAST);
        if (mode == MODE_SLOW) div_act = CNT_W'(DIV_SLOW);
    end

    assign at_bnd   = (count == div_act);
    // Update only where clk is low afterwards: a falling boundary, or while parked
    assign mode_upd = at_bnd && (clk || state == ST_PARK) && (sel_s2 != mode);
    assign new_mode = mode_upd ? sel_s2 : mode;

`ifdef BREAKPOINT_EN
    logic bp_set, bp_clr;
    assign bp_set   = clk_rise && bp_valid && (pc_in == bp_addr) && is_free_run(mode);
    assign bp_clr   = mode_upd || (step_pulse && state == ST_PARK);
    assign bp_hit_n = bp_clr ? 1'b0 : (bp_hit || bp_set);

    // Sticky breakpoint flag
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) bp_hit <= 1'b0;
        else       bp_hit <= bp_hit_n;
    end
`else
    assign bp_hit_n = 1'b0;
`endif

    // Next-state logic for mode, divider, park/run state and the step burst
    always_comb begin
        mode_n  = mode;
        state_n = state;
        count_n = count + CNT_W'(1);
        clk_n   = clk;
        rise_n  = 1'b0;
        cycle_n = cycle_count;
        step_n  = step_remain;
        if (at_bnd || mode_upd) count_n = '0;
        if (mode_upd) begin
            mode_n = sel_s2;
            step_n = '0;
        end
        case (state)
            ST_RUN: begin
                if (at_bnd) begin
                    if (!clk) begin
                        clk_n   = 1'b1;
                        rise_n  = 1'b1;
                        cycle_n = cycle_count + CYC_W'(1);
                    end else begin
                        clk_n = 1'b0;
                        if (is_free_run(new_mode)) begin
                            if (bp_hit_n) state_n = ST_PARK;
                        end else if (new_mode == MODE_STEP && !mode_upd &&
                                     step_remain > STEP_W'(1)) begin
                            step_n = step_remain - STEP_W'(1);
                        end else begin
                            step_n  = '0;
                            state_n = ST_PARK;
                        end
                    end
                end
            end
            default: begin
                if (is_free_run(new_mode)) begin
                    if (!bp_hit_n) begin
                        state_n = ST_RUN;
                        count_n = '0;
                    end
                end else if (new_mode == MODE_STEP && step_pulse) begin
                    state_n = ST_RUN;
                    count_n = '0;
                    step_n  = (step_count == '0) ? STEP_W'(1) : step_count;
                end
            end
        endcase
    end

    // State registers, sel_clock synchroniser and the press edge detector
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sel_s1      <= MODE_HALT;
            sel_s2      <= MODE_HALT;
            mode        <= MODE_HALT;
            state       <= ST_PARK;
            count       <= '0;
            clk         <= 1'b0;
            clk_rise    <= 1'b0;
            cycle_count <= '0;
            step_remain <= '0;
            deb_prev    <= 1'b0;
            armed       <= 1'b0;
        end else begin
            sel_s1      <= sel_clock;
            sel_s2      <= sel_s1;
            mode        <= mode_n;
            state       <= state_n;
            count       <= count_n;
            clk         <= clk_n;
            clk_rise    <= rise_n;
            cycle_count <= cycle_n;
            step_remain <= step_n;
            deb_prev    <= deb_level;
            armed       <= armed || (deb_settled && !deb_level);
        end
    end

endmodule

// File: doc/clk_ctrl_unit.md
Name: clk_ctrl_unit

Overview:
- Parametrised successor to the board's processor clock divider. Generates the CPU clock from CLOCK_50 in four modes: FAST, SLOW, STEP-burst and HALT.
- Mode changes are glitch-free, and a one-cycle rising-edge strobe and a CPU-cycle counter are exported for debug.
- Sits between the board clock and switches and the processor top; the debounced continue_switch drives stepping.

Parameters:
- CNT_W, 29, width of the divider counter.
- DIV_FAST, 25, half-period minus one (CLOCK_50 cycles) in FAST and STEP modes.
- DIV_SLOW, 50000000, half-period minus one in SLOW mode.
- DEB_CYCLES, 500000, CLOCK_50 cycles the switch must be stable before its debounced level changes.
- STEP_W, 4, width of step_count.
- CYC_W, 32, width of cycle_count.
- PC_W, 32, width of PC compare (used only under BREAKPOINT_EN).

Ports:
- CLOCK_50  in  1  system clock, all logic on its posedge.
- reset  in  1  asynchronous, active-high.
- sel_clock  in  2  mode select: 00 FAST, 01 SLOW, 10 STEP, 11 HALT.
- continue_switch  in  1  raw, asynchronous push switch.
- step_count  in  STEP_W  CPU cycles per press in STEP mode; 0 is treated as 1.
- clk  out  1  generated CPU clock (registered).
- clk_rise  out  1  high for one CLOCK_50 cycle, in the same cycle clk goes 0->1.
- running  out  1  high while clk is toggling (not parked).
- cycle_count  out  CYC_W  number of clk rising edges since reset; wraps.

Behaviour:
- Reset (async) values: clk=0, clk_rise=0, running=0, cycle_count=0, count=0, mode=HALT, step_remain=0, debounced level=0, edge detector disarmed.
- Divider:
  - half-period = DIV+1 CLOCK_50 cycles.
  - When count==DIV_active: clk toggles and count goes to 0; otherwise count increments.
  - DIV=0 gives a toggle every cycle.
- Mode register:
  - sel_clock passes through a 2-FF synchroniser.
  - The active mode updates only when clk==0 and at a half-period boundary (count==DIV_active), so no high pulse is ever truncated.
  - count clears on mode update.
- FAST/SLOW: continuous toggling with DIV_FAST/DIV_SLOW; running=1.
- HALT:
  - An in-progress high phase completes at full length.
  - clk then parks at 0; running=0; cycle_count frozen.
- STEP:
  - Parked low until a step pulse arrives.
  - A pulse loads step_remain = max(step_count,1) and sets running=1.
  - Each clk falling edge decrements step_remain; at 0, clk parks low and running=0.
  - Pulses arriving while running=1 are ignored.
  - Leaving STEP mid-burst: the current period finishes and the burst is abandoned.
- Step pulse:
  - Debounced level drives a rising-edge detector.
  - The detector arms only after the debounced level is seen at 0 once after reset, so a switch held at power-up gives no pulse.
  - Produces exactly one CLOCK_50-cycle pulse per press.
- clk_rise is registered with clk; cycle_count increments on the same cycle.
- Simultaneous events: a pulse on the same cycle as a mode update uses the new mode. If the new mode is not STEP, the pulse is dropped.

Optional Feature:
- Macro BREAKPOINT_EN.
- With the macro:
  - Adds ports bp_valid (in, 1), bp_addr (in, PC_W), pc_in (in, PC_W) and bp_hit (out, 1, sticky, reset 0).
  - In FAST/SLOW, on a cycle with clk_rise=1 and bp_valid and pc_in==bp_addr, bp_hit is set.
  - clk then completes that period and parks low; running=0.
  - A step pulse clears bp_hit and resumes the current mode. A change of sel_clock also clears bp_hit.
- Without the macro: these ports and the logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package clk_ctrl_pkg holds:
  - mode encoding constants MODE_FAST=2'b00, MODE_SLOW=2'b01, MODE_STEP=2'b10, MODE_HALT=2'b11;
  - the park/run state enum.
- One sub-module, switch_debouncer: 2-FF synchroniser, stability counter of DEB_CYCLES, level output; async reset to 0.
- Edge detection and burst control stay in the top.

Test Plan:
- Use DIV_FAST=1, DIV_SLOW=4, DEB_CYCLES=3, STEP_W=4.
- Reset mid-run: assert reset while clk=1 -> clk=0, clk_rise=0, cycle_count=0 in the same cycle; outputs hold while reset is high.
- sel=00 for 40 cycles after sync -> clk has period 4 (2 high, 2 low); cycle_count=10±1; clk_rise widths are all 1.
- sel=00->01 while clk is high -> current high phase lasts 2 cycles, next low phase lasts 5; no runt pulse.
- sel=10, step_count=3, switch high for 6 cycles -> exactly 3 clk_rise pulses, then clk=0 and running=0. A second press during the burst gives no extra pulses.
- Switch bounce: high 2 cycles, low 1, high 2 -> no step pulse. step_count=0 with a clean press -> exactly 1 rise.
- With BREAKPOINT_EN, sel=00, bp_addr=0x10, pc_in=4*cycle_count -> bp_hit=1 at the rise with pc_in=0x10; clk parks after that period; a clean press clears bp_hit and toggling resumes.
